// File: rtl/bcd_digit_scan_controller.sv
// Purpose : time-multiplexes one shared BCD-to-decimal decoder across NUM_DIGITS
//           positions; per frame it snapshots all digits, then shows them one at a
//           time (blank gap, then SHOW slot) with an active-low one-hot strobe.
// Latency : enable sampled high at edge t -> blank from t+1, first strobe from
//           t+1+BLANK_CYCLES; all outputs registered.
// Backpressure: none; free-running scan while enable=1, dark while enable=0.
//
// Ports:
//   clk, reset (sync, active-high), enable
//   digits_in   packed BCD, digit k at [4k+3:4k]
//   bcd_out     code to decoder, 4'hF = blank
//   digit_sel_n active-low one-hot strobe, all ones when blank
//   frame_done  1-cycle pulse on the edge that ends the last digit's SHOW slot
//   code_err    sticky flag: a shown snapshot digit was above 9
module bcd_digit_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done,
  output logic                    code_err
);

  localparam int SLOT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CW       = $clog2(SLOT_MAX + 1);
  localparam int IW       = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] snapshot;

  logic                    in_idle;
  logic                    show_end;
  logic                    blank_end;
  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] snap_src;
  logic [IW-1:0]           next_idx;
  logic [IW+1:0]           bit_base;
  logic [3:0]              next_code;
  logic                    code_bad;
  logic [NUM_DIGITS-1:0]   next_sel_n;

  // Any unexpected encoding is treated as IDLE so the scan always restarts cleanly.
  assign in_idle   = !(state == BLANK || state == SHOW);
  assign show_end  = (state == SHOW)  && (cnt == SHOW_LAST);
  assign blank_end = (state == BLANK) && (cnt == BLANK_LAST);

  // A new frame begins when leaving IDLE or when the last digit's slot ends.
  // On that edge the fresh digits_in must feed the digit being loaded, since
  // with no blanking the first digit is shown on the very same edge.
  assign frame_start = in_idle || (show_end && (idx == IDX_LAST));
  assign snap_src    = frame_start ? digits_in : snapshot;
  assign next_idx    = frame_start ? '0 : (show_end ? idx + IW'(1) : idx);
  assign bit_base    = {next_idx, 2'b00};
  assign next_code   = snap_src[bit_base +: 4];
  assign code_bad    = next_code > 4'd9;
  assign next_sel_n  = ~(SEL_ONE << next_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      snapshot    <= '0;
      bcd_out     <= 4'hF;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
      code_err    <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      bcd_out     <= 4'hF;
      digit_sel_n <= '1;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        snapshot <= digits_in;
      end
      if (show_end && (idx == IDX_LAST)) begin
        frame_done <= 1'b1;
      end

      if (in_idle || show_end || blank_end) begin
        cnt <= '0;
        idx <= next_idx;
        if (blank_end || BLANK_CYCLES == 0) begin
          // Enter a SHOW slot: strobe and code change together. Invalid codes
          // still strobe the digit but keep the decoder dark.
          state       <= SHOW;
          bcd_out     <= code_bad ? 4'hF : next_code;
          digit_sel_n <= next_sel_n;
          if (code_bad) begin
            code_err <= 1'b1;
          end
        end else begin
          state       <= BLANK;
          bcd_out     <= 4'hF;
          digit_sel_n <= '1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
